// File: rtl/cnn_pkg.sv
// Shared types and helpers for the CNN accelerator pooling stage.
// Holds the pooling FSM state type, an unsigned max and an index-width helper.
package cnn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } pool_state_t;

    localparam int UMAX_W = 32;

    function automatic logic [UMAX_W-1:0] umax(input logic [UMAX_W-1:0] a,
                                               input logic [UMAX_W-1:0] b);
        return (a >= b) ? a : b;
    endfunction

    // Index width that never collapses to zero bits for degenerate sizes.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// Half-row store of horizontal pair maxima for the 2x2 pooling stage.
// Reads and writes never target the same row, so no read-before-write ordering is needed.
module pool_line_buffer
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 128,
    parameter int AW         = 7
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/maxpool_stream.sv
// Streaming 2x2 stride-2 max-pool: raster-order pixels in, tagged pooled pixels out.
// Only one half-row of partial maxima is buffered; odd trailing rows/columns are consumed and dropped.
module maxpool_stream
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IN_HEIGHT  = 256,
    parameter int IN_WIDTH   = 256
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              en,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [DATA_WIDTH-1:0]             in_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DATA_WIDTH-1:0]             out_data,
    output logic [idx_width(IN_HEIGHT/2)-1:0] out_row,
    output logic [idx_width(IN_WIDTH/2)-1:0]  out_col,
    output logic                              done
);

    localparam int OUT_HEIGHT = IN_HEIGHT / 2;
    localparam int OUT_WIDTH  = IN_WIDTH / 2;
    localparam int RW         = idx_width(OUT_HEIGHT);
    localparam int CW         = idx_width(OUT_WIDTH);
    localparam int RCW        = idx_width(IN_HEIGHT);
    localparam int CCW        = idx_width(IN_WIDTH);
    localparam int LB_DEPTH   = (OUT_WIDTH > 0) ? OUT_WIDTH : 1;
    localparam logic [RCW-1:0] R_LAST = RCW'(IN_HEIGHT - 1);
    localparam logic [CCW-1:0] C_LAST = CCW'(IN_WIDTH - 1);
    localparam bit H_ODD = (IN_HEIGHT % 2) != 0;

    pool_state_t           state;
    logic [RCW-1:0]        r;
    logic [CCW-1:0]        c;
    logic [DATA_WIDTH-1:0] h;

    logic                  accept;
    logic                  produce;
    logic                  lb_we;
    logic                  keep_row;
    logic                  last_in;
    logic                  out_hold;
    logic [CW-1:0]         lb_addr;
    logic [DATA_WIDTH-1:0] pm;
    logic [DATA_WIDTH-1:0] lb_rdata;
    logic [DATA_WIDTH-1:0] pooled;

    function automatic logic [DATA_WIDTH-1:0] dmax(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
        return DATA_WIDTH'(umax(UMAX_W'(a), UMAX_W'(b)));
    endfunction

    assign in_ready = (state == RUN) && en && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign out_hold = out_valid && !out_ready;
    assign last_in  = accept && (r == R_LAST) && (c == C_LAST);

    // The trailing row of an odd-height map must not disturb the line buffer.
    assign keep_row = !(H_ODD && (r == R_LAST));
    assign produce  = accept && c[0] && r[0];
    assign lb_we    = accept && c[0] && !r[0] && keep_row;
    assign lb_addr  = CW'(c >> 1);

    assign pm     = dmax(h, in_data);
    assign pooled = dmax(lb_rdata, pm);

    pool_line_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (LB_DEPTH),
        .AW         (CW)
    ) u_line_buffer (
        .clk   (clk),
        .we    (lb_we),
        .addr  (lb_addr),
        .wdata (pm),
        .rdata (lb_rdata)
    );

    // Raster counters, horizontal holding register and the output register.
    // A produce in the same cycle as an output handshake reloads without a bubble.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r         <= '0;
            c         <= '0;
            h         <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_row   <= '0;
            out_col   <= '0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                if (c == C_LAST) begin
                    c <= '0;
                    r <= (r == R_LAST) ? '0 : r + 1'b1;
                end else begin
                    c <= c + 1'b1;
                end
                if (!c[0]) begin
                    h <= in_data;
                end
            end
            if (produce) begin
                out_valid <= 1'b1;
                out_data  <= pooled;
                out_row   <= RW'(r >> 1);
                out_col   <= CW'(c >> 1);
            end
        end
    end

    // Frame sequencing; DRAIN waits for the final pooled pixel to leave.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (last_in) begin
                        if (produce || out_hold) begin
                            state <= DRAIN;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (out_valid && out_ready) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    done <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_maxpool_stream.sv
// Randomized self-checking bench for maxpool_stream on a 4x4 and a 5x5 instance.
// Expected pooled pixels come from a direct 2x2 window maximum over the frame.
module tb_maxpool_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       en;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] in_data;
    int         sel;

    int checks = 0;
    int errors = 0;

    logic       rst_a, rst_b;
    logic       a_in_ready, a_out_valid, a_done;
    logic [7:0] a_out_data;
    logic [0:0] a_row, a_col;
    logic       b_in_ready, b_out_valid, b_done;
    logic [7:0] b_out_data;
    logic [0:0] b_row, b_col;

    logic       m_in_ready, m_out_valid, m_done;
    logic [7:0] m_out_data;
    int         m_row, m_col;

    assign rst_a = (sel == 0) ? rst_n : 1'b0;
    assign rst_b = (sel == 1) ? rst_n : 1'b0;

    maxpool_stream #(.DATA_WIDTH(8), .IN_HEIGHT(4), .IN_WIDTH(4)) dut4 (
        .clk(clk), .reset(rst_a), .en(en), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_data(a_out_data), .out_row(a_row), .out_col(a_col), .done(a_done)
    );

    maxpool_stream #(.DATA_WIDTH(8), .IN_HEIGHT(5), .IN_WIDTH(5)) dut5 (
        .clk(clk), .reset(rst_b), .en(en), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_data(b_out_data), .out_row(b_row), .out_col(b_col), .done(b_done)
    );

    always_comb begin
        if (sel == 0) begin
            m_in_ready  = a_in_ready;
            m_out_valid = a_out_valid;
            m_done      = a_done;
            m_out_data  = a_out_data;
            m_row       = int'(a_row);
            m_col       = int'(a_col);
        end else begin
            m_in_ready  = b_in_ready;
            m_out_valid = b_out_valid;
            m_done      = b_done;
            m_out_data  = b_out_data;
            m_row       = int'(b_row);
            m_col       = int'(b_col);
        end
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_out_valid"}, int'(m_out_valid), 0);
        checkOutput({tag, "_out_data"}, int'(m_out_data), 0);
        checkOutput({tag, "_out_row"}, m_row, 0);
        checkOutput({tag, "_out_col"}, m_col, 0);
        checkOutput({tag, "_done"}, int'(m_done), 0);
        checkOutput({tag, "_in_ready"}, int'(m_in_ready), 0);
    endtask

    // fill: 0 ramp, 1 saturated with one {255,0,0,0} window, 2 random.
    // rdyMode: 0 always ready, 1 toggles every 3 cycles, 2 random (in_valid random too).
    task automatic applyStimulus(input int dsel, input int h, input int w, input int fill,
                                 input int rdyMode, input int gapAt, input int abortAt);
        logic [7:0] pix [0:24];
        int  eD[$], eR[$], eC[$];
        int  total, nexp, nin, nout, cyc, gapLeft, m, pr, pc;
        int  holdD, holdR, holdC;
        bit  gapDone, stalled, produceNext, finished;

        total = h * w;
        for (int i = 0; i < total; i++) begin
            case (fill)
                0:       pix[i] = 8'(i);
                1:       pix[i] = 8'hFF;
                default: pix[i] = 8'($urandom_range(0, 255));
            endcase
        end
        if (fill == 1) begin
            pix[1]     = 8'h00;
            pix[w]     = 8'h00;
            pix[w + 1] = 8'h00;
        end
        for (int i = 0; i < h / 2; i++) begin
            for (int j = 0; j < w / 2; j++) begin
                m = 0;
                for (int di = 0; di < 2; di++) begin
                    for (int dj = 0; dj < 2; dj++) begin
                        if (int'(pix[(2 * i + di) * w + 2 * j + dj]) > m)
                            m = int'(pix[(2 * i + di) * w + 2 * j + dj]);
                    end
                end
                eD.push_back(m);
                eR.push_back(i);
                eC.push_back(j);
            end
        end
        nexp = eD.size();

        @(negedge clk);
        sel = dsel; rst_n = 1'b0; en = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
        @(negedge clk);
        #1;
        checkResetValues("reset");
        rst_n = 1'b1; en = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = pix[0];
        #1;
        checkOutput("idle_in_ready", int'(m_in_ready), 0);

        nin = 0; nout = 0; cyc = 0; gapLeft = 0;
        gapDone = 0; stalled = 0; produceNext = 0; finished = 0;
        holdD = 0; holdR = 0; holdC = 0;

        while (cyc < 2000) begin
            @(negedge clk);
            if (abortAt > 0 && nin == abortAt) begin
                rst_n = 1'b0; in_valid = 1'b0;
                @(negedge clk);
                #1;
                checkResetValues("abort");
                rst_n = 1'b1;
                return;
            end
            if (!gapDone && gapAt > 0 && nin == gapAt) begin
                gapDone = 1;
                gapLeft = 4;
            end
            en = (gapLeft == 0);
            if (gapLeft > 0) gapLeft--;
            in_valid = (rdyMode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data  = (nin < total) ? pix[nin] : 8'h00;
            case (rdyMode)
                0:       out_ready = 1'b1;
                1:       out_ready = ((cyc / 3) % 2 == 0);
                default: out_ready = ($urandom_range(0, 2) != 0);
            endcase
            cyc++;
            #1;

            checkOutput("done", int'(m_done), int'(nin == total && nout == nexp));
            if (m_done && nin == total && nout == nexp) begin
                finished = 1;
                break;
            end
            if (produceNext) checkOutput("latency_out_valid", int'(m_out_valid), 1);
            if (stalled) begin
                checkOutput("hold_valid", int'(m_out_valid), 1);
                checkOutput("hold_data", int'(m_out_data), holdD);
                checkOutput("hold_row", m_row, holdR);
                checkOutput("hold_col", m_col, holdC);
            end
            if (m_out_valid && !out_ready) checkOutput("stall_in_ready", int'(m_in_ready), 0);
            if (!en) checkOutput("en_low_in_ready", int'(m_in_ready), 0);
            if (nin == total) checkOutput("post_frame_in_ready", int'(m_in_ready), 0);

            produceNext = 0;
            if (m_out_valid && out_ready) begin
                if (nout < nexp) begin
                    checkOutput("out_data", int'(m_out_data), eD[nout]);
                    checkOutput("out_row", m_row, eR[nout]);
                    checkOutput("out_col", m_col, eC[nout]);
                end else begin
                    checkOutput("extra_output", int'(m_out_valid), 0);
                end
                nout++;
            end
            stalled = m_out_valid && !out_ready;
            holdD = int'(m_out_data);
            holdR = m_row;
            holdC = m_col;
            if (in_valid && m_in_ready && nin < total) begin
                pr = nin / w;
                pc = nin % w;
                if (pr % 2 == 1 && pc % 2 == 1) produceNext = 1;
                nin++;
            end
        end

        if (!finished) checkOutput("frame_timeout", nin + nout, total + nexp + 1);
        checkOutput("output_count", nout, nexp);
    endtask

    initial begin
        int s;
        sel = 0; rst_n = 1'b0; en = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
        applyStimulus(0, 4, 4, 0, 0, 0, 0);
        applyStimulus(0, 4, 4, 0, 1, 0, 0);
        applyStimulus(1, 5, 5, 0, 0, 0, 0);
        applyStimulus(0, 4, 4, 1, 0, 0, 0);
        applyStimulus(0, 4, 4, 0, 0, 6, 0);
        applyStimulus(0, 4, 4, 0, 0, 0, 10);
        applyStimulus(0, 4, 4, 0, 0, 0, 0);
        for (int k = 0; k < 12; k++) begin
            s = int'($urandom_range(0, 1));
            applyStimulus(s, (s == 1) ? 5 : 4, (s == 1) ? 5 : 4, 2, 2, int'($urandom_range(0, 8)), 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/maxpool_stream.md
# maxpool_stream

Streaming 2x2, stride-2 max-pooling stage that sits directly downstream of `cnn_accelerator`'s convolution datapath. It consumes convolution output pixels one per handshake in raster order and emits pooled pixels in raster order with `(row, col)` tags. Only one half-row of partial maxima is buffered, so a full output feature map is never stored. The pooled output map is `floor(IN_HEIGHT/2) x floor(IN_WIDTH/2)`.

## Interface
- `DATA_WIDTH`, 8: pixel width. Pixels are unsigned.
- `IN_HEIGHT`, 256: rows of the incoming convolution map.
- `IN_WIDTH`, 256: columns of the incoming convolution map.
- `OUT_HEIGHT`, `IN_HEIGHT/2` (derived localparam, floor).
- `OUT_WIDTH`, `IN_WIDTH/2` (derived localparam, floor).

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low. Sampled on `clk`; low forces the reset state.
- `en` in 1: run enable. Low pauses input acceptance; state is held.
- `in_valid` in 1: input pixel valid.
- `in_ready` out 1: input pixel accepted when `in_valid && in_ready`.
- `in_data` in `DATA_WIDTH`: convolution output pixel.
- `out_valid` out 1: pooled pixel valid.
- `out_ready` in 1: consumer accepts when `out_valid && out_ready`.
- `out_data` out `DATA_WIDTH`: pooled maximum.
- `out_row` out `$clog2(OUT_HEIGHT)`: output row index.
- `out_col` out `$clog2(OUT_WIDTH)`: output column index.
- `done` out 1: frame complete. Sticky until reset.

## Operation
- Counters `r` (0..IN_HEIGHT-1) and `c` (0..IN_WIDTH-1) advance on each input handshake. `c` wraps to 0 and increments `r` at `IN_WIDTH-1`.
- On even `c`: `h <= in_data`.
- On odd `c`: `pm = max(h, in_data)`.
  - Even `r`: `lb[c>>1] <= pm`.
  - Odd `r`: the output register loads `max(lb[c>>1], pm)`, `out_row=r>>1`, `out_col=c>>1`, and sets `out_valid`.
- Odd `IN_WIDTH`: the last column is accepted and discarded. Odd `IN_HEIGHT`: the last row is accepted and discarded (no writes, no outputs).
- Ties are resolved by value only; the result is identical whichever operand wins.
- FSM states and transitions:
  - IDLE: `en=1` → RUN.
  - RUN: after the handshake of input index `IN_HEIGHT*IN_WIDTH-1`, go to DRAIN if `out_valid` will remain set, otherwise go to DONE.
  - DRAIN: on the output handshake → DONE.
  - DONE: `done=1`, `in_ready=0`. Stays until reset.
- `in_ready = (state==RUN) && en && (!out_valid || out_ready)`. It does not depend on `in_valid`.
- `en` low mid-RUN: `in_ready` drops and counters and buffer hold. The output side still drains. Raising `en` resumes with no loss.
- Reset low at any time, including mid-frame: counters, `h`, FSM and output register clear on that edge. Line-buffer contents need no reset because they are always overwritten on an even row before being read.

## Timing
- Reset values: `in_ready=0`, `out_valid=0`, `out_data=0`, `out_row=0`, `out_col=0`, `done=0`. FSM resets to IDLE.
- IDLE → RUN takes 1 cycle, so `in_ready` is first high the cycle after `en` is sampled high.
- Latency: `out_valid` rises on the edge that accepts the odd-row, odd-column input. Data is visible the next cycle (1-cycle registered).
- The output register holds `out_data`, `out_row` and `out_col` stable while `out_valid && !out_ready`.
- Simultaneous output handshake and producing input in the same cycle: the register reloads with no bubble. Sustained throughput is 1 input/cycle when `out_ready=1`.
- `done` rises 1 cycle after the final input handshake (when nothing is pending) or after the final output handshake.

## Structure
- Shared package `cnn_pkg`:
  - FSM state enum `pool_state_t` (IDLE, RUN, DRAIN, DONE).
  - Function `umax(a,b)`.
- Sub-module `pool_line_buffer`:
  - `IN_WIDTH/2 x DATA_WIDTH` storage.
  - One write port and one combinational read port at the same address.
  - Read-before-write is not needed because reads and writes occur on disjoint rows.
- The top holds the counters, `h`, FSM and output register.

## Test plan
- 4x4 frame, values 0..15 row-major, `out_ready=1` → outputs 5,7,13,15 at (0,0),(0,1),(1,0),(1,1); `done` rises 1 cycle after the last output.
- Same 4x4 frame with `out_ready` toggling every 3 cycles → identical sequence; `in_ready` low whenever `out_valid && !out_ready`; output stable while stalled.
- 5x5 frame, values 0..24 → outputs 6,8,16,18 only; last row and column consumed; `done` after 25 inputs.
- 4x4 all 255 plus a window of {255,0,0,0} → every output 255; no overflow.
- `en` dropped for 4 cycles after the 6th input, then raised → same outputs as the uninterrupted run.
- `reset` low for 1 cycle after 10 inputs, then a fresh 4x4 frame → all outputs at reset values, then 5,7,13,15.
